// File: rtl/pcie_msi_pkg.sv
// Shared types and function-0 constants for the MSI interrupt controller.
package pcie_msi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BACKOFF = 2'd3
  } msi_state_e;

  typedef logic [4:0] vec_t;

  localparam logic [3:0] F0_SELECT        = 4'd0;
  localparam logic [3:0] F0_FUNC_NUM      = 4'd0;
  localparam logic [2:0] F0_ATTR          = 3'd0;
  localparam logic       F0_TPH_PRESENT   = 1'b0;
  localparam logic [1:0] F0_TPH_TYPE      = 2'd0;
  localparam logic [8:0] F0_TPH_ST_TAG    = 9'd0;

  // Index mask for the number of messages granted by multiple-message-enable, capped at 32
  function automatic vec_t fold_mask(input logic [2:0] mme);
    vec_t m;
    case (mme)
      3'd0:    m = 5'h00;
      3'd1:    m = 5'h01;
      3'd2:    m = 5'h03;
      3'd3:    m = 5'h07;
      3'd4:    m = 5'h0F;
      default: m = 5'h1F;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pcie_msi_irq_ctrl_rr_arb.sv
// Combinational round-robin priority encoder: first pending bit at or above rr_ptr, wrapping.
module pcie_msi_rr_arb
  import pcie_msi_pkg::*;
#(
  parameter int NUM_VECTORS = 32
) (
  input  logic [NUM_VECTORS-1:0] pending,
  input  vec_t                   rr_ptr,
  output logic                   grant_valid,
  output vec_t                   grant_idx
);

  logic [NUM_VECTORS-1:0] rotated;
  vec_t                   offset;
  logic [5:0]             sum;

  // Rotate so bit 0 is the pointer position, take the lowest set bit, then undo the rotation
  always_comb begin
    rotated     = NUM_VECTORS'({pending, pending} >> rr_ptr);
    grant_valid = 1'b0;
    offset      = 5'd0;
    for (int k = NUM_VECTORS - 1; k >= 0; k--) begin
      grant_valid = grant_valid | rotated[k];
      offset      = rotated[k] ? 5'(k) : offset;
    end
    sum       = {1'b0, rr_ptr} + {1'b0, offset};
    grant_idx = (sum >= 6'(NUM_VECTORS)) ? 5'(sum - 6'(NUM_VECTORS)) : sum[4:0];
  end

endmodule

// File: rtl/pcie_msi_irq_ctrl.sv
// Collects per-vector interrupt requests and issues them one at a time as function-0 MSIs,
// retrying failed messages after a backoff and counting those dropped past the retry limit.
module pcie_msi_irq_ctrl
  import pcie_msi_pkg::*;
#(
  parameter int NUM_VECTORS    = 32,
  parameter int RETRY_LIMIT    = 4,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_VECTORS-1:0] irq_req,
  input  logic [3:0]             cfg_interrupt_msi_enable,
  input  logic [11:0]            cfg_interrupt_msi_mmenable,
  input  logic                   cfg_interrupt_msi_sent,
  input  logic                   cfg_interrupt_msi_fail,
  output logic [31:0]            cfg_interrupt_msi_int,
  output logic [31:0]            cfg_interrupt_msi_pending_status,
  output logic [3:0]             cfg_interrupt_msi_select,
  output logic [3:0]             cfg_interrupt_msi_function_number,
  output logic [2:0]             cfg_interrupt_msi_attr,
  output logic                   cfg_interrupt_msi_tph_present,
  output logic [1:0]             cfg_interrupt_msi_tph_type,
  output logic [8:0]             cfg_interrupt_msi_tph_st_tag,
  output logic                   irq_busy,
  output logic [15:0]            irq_drop_count
);

  localparam logic [NUM_VECTORS-1:0] VEC_ONE      = NUM_VECTORS'(1'b1);
  localparam vec_t                   LAST_VEC     = 5'(NUM_VECTORS - 1);
  localparam logic [3:0]             RETRY_MAX    = 4'(RETRY_LIMIT);
  localparam logic [7:0]             BACKOFF_LAST = 8'(BACKOFF_CYCLES - 1);

  msi_state_e             state, state_next;
  vec_t                   cur_vec, cur_next, rr_ptr, rr_next, rr_inc, grant_idx, fold;
  logic                   grant_valid;
  logic [3:0]             retry, retry_next;
  logic [7:0]             backoff, backoff_next;
  logic [15:0]            drop_count, drop_next;
  logic [NUM_VECTORS-1:0] pending, pending_next, folded, clear_mask, reinstate;
  logic [31:0]            msi_int, msi_int_next;
  logic                   busy;
  logic                   unused_cfg;

  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  pcie_msi_rr_arb #(.NUM_VECTORS(NUM_VECTORS)) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign rr_inc = (cur_vec == LAST_VEC) ? 5'd0 : cur_vec + 5'd1;

  // Fold each request line onto the vectors granted by multiple-message-enable
  always_comb begin
    fold   = fold_mask(cfg_interrupt_msi_mmenable[2:0]);
    folded = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      folded = folded | (irq_req[i] ? (VEC_ONE << (5'(i) & fold)) : '0);
    end
  end

  // Next-state, pending update and strobe generation
  always_comb begin
    state_next   = state;
    cur_next     = cur_vec;
    retry_next   = retry;
    backoff_next = backoff;
    rr_next      = rr_ptr;
    drop_next    = drop_count;
    clear_mask   = '0;
    reinstate    = '0;
    case (state)
      ST_IDLE: begin
        if (cfg_interrupt_msi_enable[0] && grant_valid) begin
          state_next = ST_ISSUE;
          cur_next   = grant_idx;
          retry_next = 4'd0;
          clear_mask = VEC_ONE << grant_idx;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          rr_next    = rr_inc;
          state_next = ST_IDLE;
        end else if (cfg_interrupt_msi_fail) begin
          if (retry < RETRY_MAX) begin
            retry_next   = retry + 4'd1;
            backoff_next = 8'd0;
            state_next   = ST_BACKOFF;
          end else begin
            drop_next  = (drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            rr_next    = rr_inc;
            state_next = ST_IDLE;
          end
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_BACKOFF: begin
        // Losing enable mid-backoff hands the vector back to the pending register
        if (!cfg_interrupt_msi_enable[0]) begin
          reinstate  = VEC_ONE << cur_vec;
          state_next = ST_IDLE;
        end else if (backoff == BACKOFF_LAST) begin
          state_next = ST_ISSUE;
        end else begin
          backoff_next = backoff + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    pending_next = (pending & ~clear_mask) | folded | reinstate;
    msi_int_next = (state_next == ST_ISSUE) ? (32'h1 << cur_next) : 32'h0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_vec    <= 5'd0;
      retry      <= 4'd0;
      backoff    <= 8'd0;
      rr_ptr     <= 5'd0;
      drop_count <= 16'd0;
      pending    <= '0;
      msi_int    <= 32'h0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cur_vec    <= cur_next;
      retry      <= retry_next;
      backoff    <= backoff_next;
      rr_ptr     <= rr_next;
      drop_count <= drop_next;
      pending    <= pending_next;
      msi_int    <= msi_int_next;
      busy       <= (state_next != ST_IDLE);
    end
  end

  assign cfg_interrupt_msi_int             = msi_int;
  assign cfg_interrupt_msi_pending_status  = 32'(pending);
  assign cfg_interrupt_msi_select          = F0_SELECT;
  assign cfg_interrupt_msi_function_number = F0_FUNC_NUM;
  assign cfg_interrupt_msi_attr            = F0_ATTR;
  assign cfg_interrupt_msi_tph_present     = F0_TPH_PRESENT;
  assign cfg_interrupt_msi_tph_type        = F0_TPH_TYPE;
  assign cfg_interrupt_msi_tph_st_tag      = F0_TPH_ST_TAG;
  assign irq_busy                          = busy;
  assign irq_drop_count                    = drop_count;

endmodule
